// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
package sram_ctrl_pkg;

  localparam int ADDR_W      = 20;
  localparam int DATA_W      = 16;
  localparam int CNT_W       = 20;
  localparam int RD_WAIT_DEF = 2;
  localparam int WR_WAIT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ACC,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_e;

  // Zero the bytes whose enable is clear; be[1] selects the upper byte.
  function automatic logic [DATA_W-1:0] mask_bytes(input logic [1:0] be,
                                                   input logic [DATA_W-1:0] d);
    return {be[1] ? d[15:8] : 8'h00, be[0] ? d[7:0] : 8'h00};
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// CPU-side request/response bus of the SRAM controller.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        be;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wr, addr, be, wdata,
                  input  busy, done, rdata);

  modport slave  (input  req, wr, addr, be, wdata,
                  output busy, done, rdata);

endinterface

// File: rtl/sram_dq_buf.sv
// Tristate buffer for the bidirectional SRAM data bus.
module sram_dq_buf
  import sram_ctrl_pkg::*;
(
  input  logic              oe,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] pad
);

  assign pad = oe ? dout : {DATA_W{1'bz}};
  assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: one read or write per request,
// all SRAM strobes and the address driven straight from flops.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  inout  wire  [DATA_W-1:0] SRAM_DQ
);

  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_WAIT - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ce_n_q;
  logic              oe_n_q;
  logic              we_n_q;
  logic              ub_n_q;
  logic              lb_n_q;
  logic              dq_oe_q;
  logic [1:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] dq_in;
  logic [DATA_W-1:0] rdata_d;

  sram_dq_buf u_dq_buf (
    .oe   (dq_oe_q),
    .dout (wdata_q),
    .din  (dq_in),
    .pad  (SRAM_DQ)
  );

  assign rdata_d = mask_bytes(be_q, dq_in);

  // Request payload latched on acceptance; purely datapath, so no reset.
  always_ff @(posedge Clk) begin
    if (state_q == ST_IDLE && bus.req) begin
      be_q    <= bus.be;
      wdata_q <= bus.wdata;
    end
  end

  // Controller FSM; every strobe is updated together with the state it belongs to.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            addr_q <= bus.addr;
            busy_q <= 1'b1;
            ce_n_q <= 1'b0;
            ub_n_q <= ~bus.be[1];
            lb_n_q <= ~bus.be[0];
            if (bus.wr) begin
              state_q <= ST_WR_SETUP;
              dq_oe_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_RD_ACC;
              oe_n_q  <= 1'b0;
              cnt_q   <= RD_CNT;
            end
          end
        end
        ST_RD_ACC: begin
          if (cnt_q == '0) begin
            rdata_q <= rdata_d;
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WR_SETUP: begin
          state_q <= ST_WR_PULSE;
          we_n_q  <= 1'b0;
          cnt_q   <= WR_CNT;
        end
        ST_WR_PULSE: begin
          if (cnt_q == '0) begin
            state_q <= ST_WR_HOLD;
            we_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WR_HOLD: begin
          // DQ is released here, so the bus is idle for a full cycle before any read.
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          ce_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: controller paired with a behavioural SRAM, a
// transaction-level reference model and directed scenarios.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int RDW = 2;
  localparam int WRW = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [19:0] sram_addr;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  wire  [15:0] sram_dq;

  sram_ctrl_if bus_if();

  sram_ctrl #(.RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus_if),
    .SRAM_ADDR (sram_addr),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .SRAM_WE_N (we_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_DQ   (sram_dq)
  );

  always #5 Clk = ~Clk;

  // Behavioural asynchronous SRAM (256 words are enough for the scenarios).
  logic [15:0] mem [0:255];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

  // SRAM write: bytes with their strobe low are stored while WE_N and CE_N are low.
  always @(posedge Clk) begin
    if (!ce_n && !we_n) begin
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
      if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int          cyc    = 0;
  bit          mvalid = 1'b0;
  int          m_A    = -100;
  int          m_last = -1;
  int          m_done = -1;
  bit          m_wr;
  logic [1:0]  m_be;
  logic [19:0] m_addr;
  logic [15:0] m_rdata, m_rnext;
  logic [15:0] ref_mem [0:255];

  // Model: a request is taken on an edge whose preceding cycle was idle.
  always @(posedge Clk) begin
    cyc = cyc + 1;
    if (Reset) begin
      mvalid  = 1'b1;
      m_last  = -1;
      m_done  = -1;
      m_addr  = '0;
      m_rdata = '0;
    end else if (mvalid && (cyc - 1 > m_last) && bus_if.req) begin
      m_A    = cyc;
      m_wr   = bus_if.wr;
      m_be   = bus_if.be;
      m_addr = bus_if.addr;
      m_last = cyc + (bus_if.wr ? WRW + 3 : RDW + 1) - 1;
      m_done = m_last;
      if (bus_if.wr) begin
        if (bus_if.be[1]) ref_mem[bus_if.addr[7:0]][15:8] = bus_if.wdata[15:8];
        if (bus_if.be[0]) ref_mem[bus_if.addr[7:0]][7:0]  = bus_if.wdata[7:0];
      end else begin
        m_rnext = {bus_if.be[1] ? ref_mem[bus_if.addr[7:0]][15:8] : 8'h00,
                   bus_if.be[0] ? ref_mem[bus_if.addr[7:0]][7:0]  : 8'h00};
      end
    end
  end

  // Compare: every cycle after the first reset edge, outputs against the model.
  always @(negedge Clk) begin
    if (mvalid) begin
      automatic int c   = cyc;
      automatic bit act = (c >= m_A) && (c <= m_last);
      automatic int r   = c - m_A;
      automatic logic e_ce = 1, e_oe = 1, e_we = 1, e_ub = 1, e_lb = 1, e_dq = 0;
      automatic bit   chk_bytes = 1'b1;
      if (c == m_done && !m_wr) m_rdata = m_rnext;
      if (act) begin
        if (!m_wr) begin
          if (r < RDW) begin
            e_ce = 0; e_oe = 0; e_ub = ~m_be[1]; e_lb = ~m_be[0];
          end
        end else begin
          if (r < WRW + 2) begin e_ce = 0; e_dq = 1; end
          if (r >= 1 && r <= WRW) begin e_we = 0; e_ub = ~m_be[1]; e_lb = ~m_be[0]; end
          if (r == 0 || r == WRW + 1) chk_bytes = 1'b0;
        end
      end
      chk("busy",  32'(bus_if.busy),  32'(act));
      chk("done",  32'(bus_if.done),  32'(c == m_done));
      chk("rdata", 32'(bus_if.rdata), 32'(m_rdata));
      chk("addr",  32'(sram_addr),    32'(m_addr));
      chk("ce_n",  32'(ce_n),         32'(e_ce));
      chk("oe_n",  32'(oe_n),         32'(e_oe));
      chk("we_n",  32'(we_n),         32'(e_we));
      chk("dq_oe", 32'(dut.dq_oe_q),  32'(e_dq));
      if (chk_bytes) begin
        chk("ub_n", 32'(ub_n), 32'(e_ub));
        chk("lb_n", 32'(lb_n), 32'(e_lb));
      end
      chk("oe_dq_overlap", 32'(!oe_n && dut.dq_oe_q), 32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic txn(input bit wr, input logic [19:0] a, input logic [1:0] be,
                     input logic [15:0] wd, output int lat);
    @(negedge Clk);
    bus_if.req = 1'b1; bus_if.wr = wr; bus_if.addr = a; bus_if.be = be; bus_if.wdata = wd;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge Clk);
      bus_if.req = 1'b0;
      if (bus_if.done) begin lat = n; break; end
    end
    if (lat < 0) chk("txn_timeout", 32'hFFFF_FFFF, 32'd0);
    @(posedge Clk);
  endtask

  initial begin
    int lat, pulses, first_c, last_c, extra;
    bit seen;
    Reset = 1'b1;
    bus_if.req = 1'b1; bus_if.wr = 1'b0; bus_if.addr = 20'h5; bus_if.be = 2'b11;
    bus_if.wdata = 16'h0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_busy",  32'(bus_if.busy),  32'd0);
    chk("rst_rdata", 32'(bus_if.rdata), 32'd0);
    chk("rst_addr",  32'(sram_addr),    32'd0);
    chk("rst_we_n",  32'(we_n),         32'd1);
    chk("rst_dq_oe", 32'(dut.dq_oe_q),  32'd0);
    Reset = 1'b0; bus_if.req = 1'b0;
    @(posedge Clk);

    txn(1'b1, 20'h00010, 2'b11, 16'hBEEF, lat);  chk("wr_latency", 32'(lat), 32'd5);
    txn(1'b0, 20'h00010, 2'b11, 16'h0000, lat);  chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_beef", 32'(bus_if.rdata), 32'h0000BEEF);

    txn(1'b1, 20'h00020, 2'b11, 16'h1234, lat);
    txn(1'b1, 20'h00020, 2'b10, 16'hAB00, lat);
    txn(1'b0, 20'h00020, 2'b11, 16'h0000, lat);
    chk("rd_ab34", 32'(bus_if.rdata), 32'h0000AB34);

    txn(1'b1, 20'h00030, 2'b11, 16'hCAFE, lat);
    txn(1'b0, 20'h00030, 2'b01, 16'h0000, lat);
    chk("rd_00fe", 32'(bus_if.rdata), 32'h000000FE);

    // Reset in the middle of the write pulse.
    @(negedge Clk);
    bus_if.req = 1'b1; bus_if.wr = 1'b1; bus_if.addr = 20'h00040; bus_if.be = 2'b11;
    bus_if.wdata = 16'h5A5A;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      bus_if.req = 1'b0;
      if (!we_n) begin seen = 1'b1; break; end
    end
    chk("abort_reach_pulse", 32'(seen), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    chk("abort_we_n",  32'(we_n),         32'd1);
    chk("abort_busy",  32'(bus_if.busy),  32'd0);
    chk("abort_dq_oe", 32'(dut.dq_oe_q),  32'd0);
    Reset = 1'b0;
    extra = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus_if.done) extra++;
      @(negedge Clk);
    end
    chk("abort_no_done", 32'(extra), 32'd0);

    // req held high across four back-to-back reads.
    bus_if.req = 1'b1; bus_if.wr = 1'b0; bus_if.addr = 20'h00010; bus_if.be = 2'b11;
    pulses = 0; first_c = 0; last_c = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge Clk);
      if (bus_if.done) begin
        pulses++;
        if (pulses == 1) first_c = cyc;
        last_c = cyc;
        if (pulses == 4) begin bus_if.req = 1'b0; break; end
      end
    end
    chk("b2b_pulses",  32'(pulses),          32'd4);
    chk("b2b_spacing", 32'(last_c - first_c), 32'd12);
    chk("b2b_rdata",   32'(bus_if.rdata),     32'h0000BEEF);
    extra = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge Clk);
      if (bus_if.done) extra++;
    end
    chk("b2b_no_extra", 32'(extra), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter RD_WAIT, default 2: number of cycles the read strobes are held before data capture (min 1).
REQ-002 Parameter WR_WAIT, default 2: number of cycles SRAM_WE_N is held low per write (min 1).
REQ-003 Clk  in  1  system clock; all state updates on the rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 req  in  1  CPU request; sampled only in IDLE.
REQ-006 wr  in  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  in  20  word address; sampled with req.
REQ-008 be  in  2  byte enables, [1] = upper byte, [0] = lower byte; sampled with req.
REQ-009 wdata  in  16  write data; sampled with req.
REQ-010 busy  out  1  high whenever the state is not IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 rdata  out  16  registered read data; valid when done follows a read, then held.
REQ-013 SRAM_ADDR  out  20  registered SRAM address.
REQ-014 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes; all are registered.
REQ-015 SRAM_DQ  inout  16  SRAM data bus; driven only while writing, otherwise high-Z.

Function
REQ-016 The FSM SHALL have the states IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD and DONE.
REQ-017 In IDLE, req=1 SHALL latch addr/wr/be/wdata; the next state SHALL be RD_ACC (wr=0) or WR_SETUP (wr=1).
REQ-018 req outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-019 RD_ACC SHALL drive CE_N=0, OE_N=0, WE_N=1, UB_N=~be[1], LB_N=~be[0] for RD_WAIT cycles.
REQ-020 On the last RD_ACC edge, rdata SHALL capture SRAM_DQ per byte; disabled bytes SHALL read 8'h00.
REQ-021 WR_SETUP SHALL last 1 cycle with CE_N=0, OE_N=1, WE_N=1, DQ driven with the latched wdata.
REQ-022 WR_PULSE SHALL last WR_WAIT cycles with WE_N=0 and UB_N/LB_N from the latched be.
REQ-023 WR_HOLD SHALL last 1 cycle with WE_N=1, CE_N=0 and DQ still driven.
REQ-024 DONE SHALL last 1 cycle with done=1 and all strobes high, then return to IDLE.
REQ-025 Read latency SHALL be done high RD_WAIT+1 edges after the accepting edge; a back-to-back req is accepted in IDLE at the earliest.
REQ-026 Write latency SHALL be done high WR_WAIT+3 edges after the accepting edge.
REQ-027 A write with be=2'b00 SHALL run the full sequence with UB_N=LB_N=1, so no byte is written.
REQ-028 OE_N and DQ drive SHALL never be active in the same cycle (bus turnaround guaranteed by IDLE/DONE).
REQ-029 In IDLE, CE_N/OE_N/WE_N/UB_N/LB_N SHALL be 1 and SRAM_ADDR SHALL hold its last value.
REQ-030 A 20-bit wait counter SHALL count down and load RD_WAIT-1 or WR_WAIT-1 on state entry, with no wrap.

Reset
REQ-031 Reset SHALL force IDLE at the next edge from any state, aborting an in-flight access.
REQ-032 On reset, all strobes SHALL be 1, DQ SHALL be high-Z, and busy, done, rdata and SRAM_ADDR SHALL be 0.
REQ-033 A write aborted by Reset SHALL deassert WE_N in the same edge; the SRAM contents are unspecified.

Structure
REQ-034 The state enum and default wait constants SHALL live in shared package sram_ctrl_pkg.
REQ-035 The tristate DQ driver SHALL be sub-module sram_dq_buf (oe, dout, din, inout pad).

Verification (bench pairs the controller with the SRAM behavioral model)
REQ-036 Write addr=20'h00010, wdata=16'hBEEF, be=11, then read -> rdata=16'hBEEF, done latencies 5 and 3.
REQ-037 Write 16'h1234 to 0x20, then write 16'hAB00 with be=10, then read -> rdata=16'hAB34.
REQ-038 Read with be=01 of a word holding 16'hCAFE -> rdata=16'h00FE.
REQ-039 Assert Reset during WR_PULSE -> next cycle IDLE, WE_N=1, DQ=Z, busy=0, done never pulses.
REQ-040 req held high continuously with 4 reads -> exactly 4 done pulses, one IDLE cycle between them, OE_N/DQ-drive overlap never observed.
